demux4_scheduler: RTL and testbench

Sequencing controller for the 1-to-4 demultiplexer datapath: accepts a single input word stream and dispatches each word to exactly one of four output lanes. Lane choice is round-robin over enabled lanes, or fixed by a 2-bit select. The block owns the holding register, lane pointer and handshakes; downstream lane logic only sees a shared data bus plus one-hot valid.

---
 rtl/demux4_pkg.sv | 17 +
 rtl/demux4_scheduler_rr_pick4.sv | 32 +++
 rtl/demux4_scheduler.sv | 110 +++++++++++
 tb/tb_demux4_scheduler.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/demux4_pkg.sv
`default_nettype none
// ============================================================================
// demux4_pkg : shared types and constants for the 1-to-4 demux scheduler
// Revision   : 1.0
// ============================================================================
package demux4_pkg;

  localparam int NUM_LANES = 4;
  localparam int LANE_W    = 2;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

endpackage
`default_nettype wire

// File: rtl/demux4_scheduler_rr_pick4.sv
`default_nettype none
// ============================================================================
// rr_pick4 : first set mask bit searching cyclically upward from ptr
// Revision : 1.0
// ============================================================================
module rr_pick4
  import demux4_pkg::*;
(
  input  logic [LANE_W-1:0]    ptr,
  input  logic [NUM_LANES-1:0] mask,
  output logic [LANE_W-1:0]    lane,
  output logic                 found
);

  logic [LANE_W-1:0] idx;

  // Walk offsets from farthest to nearest so the nearest enabled lane wins.
  always_comb begin
    lane  = ptr;
    found = 1'b0;
    idx   = '0;
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      idx = ptr + LANE_W'(i);
      if (mask[idx]) begin
        lane  = idx;
        found = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/demux4_scheduler.sv
`default_nettype none
// ============================================================================
// demux4_scheduler : holds one word and dispatches it to one of four lanes
// Revision         : 1.0
// ============================================================================
module demux4_scheduler
  import demux4_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int COUNT_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic [WIDTH-1:0]     in_data,
  output logic                 in_ready,
  input  logic                 mode,
  input  logic [LANE_W-1:0]    sel,
  input  logic [NUM_LANES-1:0] lane_en,
  output logic [NUM_LANES-1:0] out_valid,
  output logic [WIDTH-1:0]     out_data,
  input  logic [NUM_LANES-1:0] out_ready,
  output logic [COUNT_W-1:0]   xfer_count,
  output logic [LANE_W-1:0]    cur_lane
);

  state_t             state_q,    state_d;
  logic [WIDTH-1:0]   hold_q,     hold_d;
  logic [LANE_W-1:0]  cur_lane_q, cur_lane_d;
  logic [LANE_W-1:0]  rr_ptr_q,   rr_ptr_d;
  logic               mode_q,     mode_d;
  logic [COUNT_W-1:0] count_q,    count_d;

  logic [LANE_W-1:0]  pick_lane;
  logic               pick_found;
  logic [LANE_W-1:0]  target;
  logic               has_target;

  rr_pick4 u_pick (
    .ptr   (rr_ptr_q),
    .mask  (lane_en),
    .lane  (pick_lane),
    .found (pick_found)
  );

  assign target     = mode ? sel : pick_lane;
  assign has_target = mode | pick_found;

  always_comb begin
    in_ready  = (state_q == ST_IDLE) && has_target;
    out_valid = '0;
    if (state_q == ST_HOLD) begin
      out_valid[cur_lane_q] = 1'b1;
    end
    out_data   = hold_q;
    cur_lane   = cur_lane_q;
    xfer_count = count_q;
  end

  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    cur_lane_d = cur_lane_q;
    rr_ptr_d   = rr_ptr_q;
    mode_d     = mode_q;
    count_d    = count_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid && has_target) begin
          hold_d     = in_data;
          cur_lane_d = target;
          mode_d     = mode;
          state_d    = ST_HOLD;
        end
      end
      ST_HOLD: begin
        // Only the targeted lane's ready matters; the mode captured with the
        // word decides whether the round-robin pointer advances.
        if (out_ready[cur_lane_q]) begin
          state_d = ST_IDLE;
          count_d = count_q + 1'b1;
          if (!mode_q) begin
            rr_ptr_d = cur_lane_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      hold_q     <= '0;
      cur_lane_q <= '0;
      rr_ptr_q   <= '0;
      mode_q     <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      cur_lane_q <= cur_lane_d;
      rr_ptr_q   <= rr_ptr_d;
      mode_q     <= mode_d;
      count_q    <= count_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_demux4_scheduler.sv
`default_nettype none
// ============================================================================
// tb_demux4_scheduler : vector table, directed corner cases, random vs model
// Revision            : 1.0
// ============================================================================
module tb_demux4_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic [3:0] in_data;
  logic       in_ready;
  logic       mode;
  logic [1:0] sel;
  logic [3:0] lane_en;
  logic [3:0] out_valid;
  logic [3:0] out_data;
  logic [3:0] out_ready;
  logic [7:0] xfer_count;
  logic [1:0] cur_lane;

  int n_tests = 0;
  int n_fail  = 0;

  demux4_scheduler #(.WIDTH(4), .COUNT_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .mode       (mode),
    .sel        (sel),
    .lane_en    (lane_en),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .xfer_count (xfer_count),
    .cur_lane   (cur_lane)
  );

  always #5 clk = ~clk;

  // Reference model: one word slot, a target lane, a pointer and a counter.
  bit         m_busy;
  bit         m_mode;
  logic [3:0] m_word;
  int         m_tgt;
  int         m_ptr;
  int         m_cnt;

  function automatic int m_pick();
    if (mode) return int'(sel);
    for (int o = 0; o < 4; o++) begin
      if (lane_en[(m_ptr + o) % 4]) return (m_ptr + o) % 4;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_mode = 0; m_word = 4'h0; m_tgt = 0; m_ptr = 0; m_cnt = 0;
  endtask

  task automatic model_update();
    int p;
    p = m_pick();
    if (!m_busy) begin
      if (in_valid && p >= 0) begin
        m_busy = 1; m_word = in_data; m_tgt = p; m_mode = mode;
      end
    end else if (out_ready[m_tgt]) begin
      m_busy = 0;
      m_cnt  = (m_cnt + 1) % 256;
      if (!m_mode) m_ptr = (m_tgt + 1) % 4;
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".in_ready"},   32'(in_ready),   32'(!m_busy && (m_pick() >= 0)));
    chk({tag, ".out_valid"},  32'(out_valid),  m_busy ? 32'(4'b0001 << m_tgt) : 32'h0);
    chk({tag, ".out_data"},   32'(out_data),   32'(m_word));
    chk({tag, ".cur_lane"},   32'(cur_lane),   32'(m_tgt));
    chk({tag, ".xfer_count"}, 32'(xfer_count), 32'(m_cnt));
  endtask

  task automatic apply(input logic m, input logic [1:0] s, input logic [3:0] en,
                       input logic iv, input logic [3:0] d, input logic [3:0] ordy);
    mode = m; sel = s; lane_en = en; in_valid = iv; in_data = d; out_ready = ordy;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  typedef struct {
    bit         pre_rst;
    logic       m;
    logic [1:0] s;
    logic [3:0] en;
    logic       iv;
    logic [3:0] d;
    logic [3:0] ordy;
    logic       e_ir;
    logic [3:0] e_ov;
    logic [3:0] e_od;
    logic [1:0] e_lane;
    logic [7:0] e_cnt;
  } vec_t;

  vec_t vt[20];

  initial begin
    reset = 1'b1; in_valid = 0; in_data = 0; mode = 0; sel = 0; lane_en = 0; out_ready = 0;
    model_reset();

    // Round-robin over all lanes, words 1..5 -> lanes 0,1,2,3,0.
    vt[0]  = '{1, 0, 0, 4'b1111, 1, 1, 4'b1111, 1, 4'b0000, 0, 0, 0};
    vt[1]  = '{0, 0, 0, 4'b1111, 0, 0, 4'b1111, 0, 4'b0001, 1, 0, 0};
    vt[2]  = '{0, 0, 0, 4'b1111, 1, 2, 4'b1111, 1, 4'b0000, 1, 0, 1};
    vt[3]  = '{0, 0, 0, 4'b1111, 0, 0, 4'b1111, 0, 4'b0010, 2, 1, 1};
    vt[4]  = '{0, 0, 0, 4'b1111, 1, 3, 4'b1111, 1, 4'b0000, 2, 1, 2};
    vt[5]  = '{0, 0, 0, 4'b1111, 0, 0, 4'b1111, 0, 4'b0100, 3, 2, 2};
    vt[6]  = '{0, 0, 0, 4'b1111, 1, 4, 4'b1111, 1, 4'b0000, 3, 2, 3};
    vt[7]  = '{0, 0, 0, 4'b1111, 0, 0, 4'b1111, 0, 4'b1000, 4, 3, 3};
    vt[8]  = '{0, 0, 0, 4'b1111, 1, 5, 4'b1111, 1, 4'b0000, 4, 3, 4};
    vt[9]  = '{0, 0, 0, 4'b1111, 0, 0, 4'b1111, 0, 4'b0001, 5, 0, 4};
    vt[10] = '{0, 0, 0, 4'b1111, 0, 0, 4'b1111, 1, 4'b0000, 5, 0, 5};
    // Sparse mask 1010 from pointer 0 -> lanes 1,3,1; then empty mask stalls.
    vt[11] = '{1, 0, 0, 4'b1010, 1, 6, 4'b1111, 1, 4'b0000, 0, 0, 0};
    vt[12] = '{0, 0, 0, 4'b1010, 0, 0, 4'b1111, 0, 4'b0010, 6, 1, 0};
    vt[13] = '{0, 0, 0, 4'b1010, 1, 7, 4'b1111, 1, 4'b0000, 6, 1, 1};
    vt[14] = '{0, 0, 0, 4'b1010, 0, 0, 4'b1111, 0, 4'b1000, 7, 3, 1};
    vt[15] = '{0, 0, 0, 4'b1010, 1, 8, 4'b1111, 1, 4'b0000, 7, 3, 2};
    vt[16] = '{0, 0, 0, 4'b1010, 0, 0, 4'b1111, 0, 4'b0010, 8, 1, 2};
    vt[17] = '{0, 0, 0, 4'b0000, 1, 9, 4'b1111, 0, 4'b0000, 8, 1, 3};
    vt[18] = '{0, 0, 0, 4'b0000, 1, 9, 4'b1111, 0, 4'b0000, 8, 1, 3};
    vt[19] = '{0, 0, 0, 4'b0000, 1, 9, 4'b1111, 0, 4'b0000, 8, 1, 3};

    for (int i = 0; i < 20; i++) begin
      if (vt[i].pre_rst) do_reset();
      apply(vt[i].m, vt[i].s, vt[i].en, vt[i].iv, vt[i].d, vt[i].ordy);
      chk($sformatf("vec%0d.in_ready", i),   32'(in_ready),   32'(vt[i].e_ir));
      chk($sformatf("vec%0d.out_valid", i),  32'(out_valid),  32'(vt[i].e_ov));
      chk($sformatf("vec%0d.out_data", i),   32'(out_data),   32'(vt[i].e_od));
      chk($sformatf("vec%0d.cur_lane", i),   32'(cur_lane),   32'(vt[i].e_lane));
      chk($sformatf("vec%0d.xfer_count", i), 32'(xfer_count), 32'(vt[i].e_cnt));
      tick();
    end

    // Fixed lane 2 with a 4-cycle stall; other lanes ready, controls toggled.
    do_reset();
    apply(1, 2'b10, 4'b0001, 1, 9, 4'b1011);
    chk("fix.capture_ready", 32'(in_ready), 32'h1);
    tick();
    for (int c = 0; c < 4; c++) begin
      apply(c[0], 2'(c), 4'(c * 5), 1, 4'(c), 4'b1011);
      chk("fix.stall_valid", 32'(out_valid), 32'h4);
      chk("fix.stall_data",  32'(out_data),  32'h9);
      chk("fix.stall_lane",  32'(cur_lane),  32'h2);
      chk("fix.stall_ready", 32'(in_ready),  32'h0);
      tick();
    end
    apply(0, 2'b01, 4'b0000, 0, 0, 4'b0100);
    chk("fix.xfer_valid", 32'(out_valid), 32'h4);
    tick();
    apply(1, 2'b10, 4'b1111, 0, 0, 4'b0000);
    chk("fix.after_valid", 32'(out_valid),  32'h0);
    chk("fix.after_count", 32'(xfer_count), 32'h1);
    chk_model("fix.after");

    // Asynchronous reset while holding word 7.
    apply(0, 0, 4'b1111, 1, 7, 4'b0000);
    tick();
    chk("ar.hold_data", 32'(out_data), 32'h7);
    reset = 1'b1;
    #1;
    chk("ar.valid_now", 32'(out_valid),  32'h0);
    chk("ar.count_now", 32'(xfer_count), 32'h0);
    chk("ar.data_now",  32'(out_data),   32'h0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    apply(0, 0, 4'b1111, 1, 3, 4'b1111);
    chk("ar.ready_after", 32'(in_ready), 32'h1);
    tick();
    chk("ar.lane_after",  32'(out_valid), 32'h1);
    chk_model("ar.after");

    // Counter wrap.
    do_reset();
    for (int w = 0; w < 255; w++) begin
      apply(0, 0, 4'b1111, 1, 4'(w), 4'b1111);
      tick();
      apply(0, 0, 4'b1111, 0, 0, 4'b1111);
      tick();
    end
    chk("wrap.at_255", 32'(xfer_count), 32'd255);
    apply(0, 0, 4'b1111, 1, 4'hA, 4'b1111);
    tick();
    apply(0, 0, 4'b1111, 0, 0, 4'b1111);
    tick();
    chk("wrap.to_0", 32'(xfer_count), 32'd0);
    chk_model("wrap");

    // Random traffic against the model.
    for (int r = 0; r < 400; r++) begin
      apply(1'($urandom_range(0, 1)), 2'($urandom), ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom),
            1'($urandom_range(0, 3) != 0), 4'($urandom), 4'($urandom));
      chk_model($sformatf("rnd%0d", r));
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
